// File: rtl/seven_seg_capture.sv
// Snoops a multiplexed 7-segment display bus and reconstructs per-digit BCD/DP values.
// A pattern is accepted after STABLE_CNT identical samples with exactly one digit common low.
module seven_seg_capture #(
  parameter int NUM_DIG    = 8,
  parameter int STABLE_CNT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           SEG_DATA,
  input  logic [NUM_DIG-1:0]   SEG_COM,
  output logic [4*NUM_DIG-1:0] BCD_OUT,
  output logic [NUM_DIG-1:0]   DOT_OUT,
  output logic [NUM_DIG-1:0]   DIG_VALID,
  output logic                 ERR,
  output logic [3:0]           ERR_DIG,
  output logic                 FRAME_DONE
);

  localparam int         IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCEPT,
    ST_LOCKED
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } dec_t;

  function automatic logic f_one_low(input logic [NUM_DIG-1:0] com);
    int zeros;
    zeros = 0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!com[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  function automatic logic [3:0] f_low_idx(input logic [NUM_DIG-1:0] com);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!com[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic dec_t f_decode(input logic [6:0] segs);
    case (segs)
      7'b1111110: return '{ok: 1'b1, val: 4'd0};
      7'b0110000: return '{ok: 1'b1, val: 4'd1};
      7'b1101101: return '{ok: 1'b1, val: 4'd2};
      7'b1111001: return '{ok: 1'b1, val: 4'd3};
      7'b0110011: return '{ok: 1'b1, val: 4'd4};
      7'b1011011: return '{ok: 1'b1, val: 4'd5};
      7'b1011111: return '{ok: 1'b1, val: 4'd6};
      7'b1110000: return '{ok: 1'b1, val: 4'd7};
      7'b1111111: return '{ok: 1'b1, val: 4'd8};
      7'b1111011: return '{ok: 1'b1, val: 4'd9};
      7'b0000000: return '{ok: 1'b1, val: 4'hF};
      default:    return '{ok: 1'b0, val: 4'h0};
    endcase
  endfunction

  state_t               r_state;
  logic [7:0]           r_seg;
  logic [NUM_DIG-1:0]   r_com;
  logic [3:0]           r_cnt;
  logic [NUM_DIG-1:0]   r_seen;
  logic [4*NUM_DIG-1:0] r_bcd;
  logic [NUM_DIG-1:0]   r_dot;
  logic [NUM_DIG-1:0]   r_valid;
  logic                 r_err;
  logic [3:0]           r_err_dig;
  logic                 r_frame;

  logic                 w_in_legal;
  logic                 w_same;
  logic [3:0]           w_cnt_nxt;
  logic [3:0]           w_sel;
  logic [IDX_W-1:0]     w_idx;
  dec_t                 w_dec;
  logic [NUM_DIG-1:0]   w_seen_set;

  // The counter tracks how long the value being loaded into the sample register has been stable,
  // so it always describes the sample register contents after the same edge.
  assign w_in_legal = f_one_low(SEG_COM);
  assign w_same     = ({SEG_DATA, SEG_COM} == {r_seg, r_com});
  assign w_sel      = f_low_idx(r_com);
  assign w_idx      = w_sel[IDX_W-1:0];
  assign w_dec      = f_decode(r_seg[7:1]);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_in_legal) begin
      if (!w_same)               w_cnt_nxt = 4'd1;
      else if (r_cnt >= CNT_MAX) w_cnt_nxt = CNT_MAX;
      else                       w_cnt_nxt = r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_seen_set        = r_seen;
    w_seen_set[w_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_seg     <= '0;
      r_com     <= '0;
      r_cnt     <= '0;
      r_seen    <= '0;
      r_bcd     <= '0;
      r_dot     <= '0;
      r_valid   <= '0;
      r_err     <= 1'b0;
      r_err_dig <= '0;
      r_frame   <= 1'b0;
    end else begin
      r_seg   <= SEG_DATA;
      r_com   <= SEG_COM;
      r_cnt   <= w_cnt_nxt;
      r_err   <= 1'b0;
      r_frame <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_in_legal) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!w_in_legal)                r_state <= ST_IDLE;
          else if (w_cnt_nxt == CNT_MAX) r_state <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (w_dec.ok) begin
            r_bcd[4*w_idx +: 4] <= w_dec.val;
            r_dot[w_idx]        <= r_seg[0];
            r_valid[w_idx]      <= 1'b1;
          end else begin
            r_err     <= 1'b1;
            r_err_dig <= w_sel;
          end
          // A faulty digit still counts toward the frame so one bad digit cannot stall it.
          if (&w_seen_set) begin
            r_frame <= 1'b1;
            r_seen  <= '0;
          end else begin
            r_seen <= w_seen_set;
          end
          // The bus may already have moved on at this edge; re-filter rather than lock.
          if (!w_in_legal)  r_state <= ST_IDLE;
          else if (!w_same) r_state <= ST_WAIT;
          else              r_state <= ST_LOCKED;
        end
        ST_LOCKED: begin
          if (!w_in_legal)  r_state <= ST_IDLE;
          else if (!w_same) r_state <= ST_WAIT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BCD_OUT    = r_bcd;
  assign DOT_OUT    = r_dot;
  assign DIG_VALID  = r_valid;
  assign ERR        = r_err;
  assign ERR_DIG    = r_err_dig;
  assign FRAME_DONE = r_frame;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios followed by random bus traffic,
// compared every cycle against a sample-history reference model.
module tb_seven_seg_capture;

  localparam int NUM_DIG    = 8;
  localparam int STABLE_CNT = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  seg_data;
  logic [7:0]  seg_com;
  logic [31:0] bcd_out;
  logic [7:0]  dot_out;
  logic [7:0]  dig_valid;
  logic        err;
  logic [3:0]  err_dig;
  logic        frame_done;

  seven_seg_capture #(.NUM_DIG(NUM_DIG), .STABLE_CNT(STABLE_CNT)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .SEG_DATA   (seg_data),
    .SEG_COM    (seg_com),
    .BCD_OUT    (bcd_out),
    .DOT_OUT    (dot_out),
    .DIG_VALID  (dig_valid),
    .ERR        (err),
    .ERR_DIG    (err_dig),
    .FRAME_DONE (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] dig_pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  logic [15:0] hist [$];
  logic [31:0] m_bcd;
  logic [7:0]  m_dot;
  logic [7:0]  m_valid;
  logic [7:0]  m_seen;
  logic        m_err;
  logic [3:0]  m_err_dig;
  logic        m_frame;

  int checks = 0;
  int errors = 0;
  int frame_pulses = 0;
  int err_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_com(input logic [7:0] com);
    return $countones(~com) == 1;
  endfunction

  function automatic int low_idx(input logic [7:0] com);
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!com[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [7:0] seg_of(input int v, input logic dp);
    return {dig_pat[v], dp};
  endfunction

  function automatic logic [7:0] com_of(input int d);
    logic [7:0] c;
    c    = 8'hFF;
    c[d] = 1'b0;
    return c;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_bcd = '0; m_dot = '0; m_valid = '0; m_seen = '0;
    m_err = 1'b0; m_err_dig = '0; m_frame = 1'b0;
  endtask

  task automatic apply_accept(input logic [15:0] p);
    logic [7:0] seg;
    int         d;
    int         val;
    seg = p[15:8];
    d   = low_idx(p[7:0]);
    val = -1;
    for (int v = 0; v < 10; v++) begin
      if (dig_pat[v] == seg[7:1]) val = v;
    end
    if (seg[7:1] == 7'b0) val = 15;
    if (val >= 0) begin
      m_bcd[4*d +: 4] = 4'(val);
      m_dot[d]        = seg[0];
      m_valid[d]      = 1'b1;
    end else begin
      m_err     = 1'b1;
      m_err_dig = 4'(d);
    end
    m_seen[d] = 1'b1;
    if (&m_seen) begin
      m_frame = 1'b1;
      m_seen  = '0;
    end
  endtask

  // Outputs after edge k reflect an accept when samples k-STABLE_CNT..k-1 are identical,
  // legal, and start a fresh run (the sample before them differs or does not exist).
  task automatic model_edge(input logic [15:0] smp);
    int          k;
    logic [15:0] p;
    bit          ok;
    hist.push_back(smp);
    m_err   = 1'b0;
    m_frame = 1'b0;
    k = hist.size() - 1;
    if (k >= STABLE_CNT) begin
      p  = hist[k-1];
      ok = legal_com(p[7:0]);
      for (int j = k - STABLE_CNT; j < k; j++) begin
        if (hist[j] !== p) ok = 1'b0;
      end
      if ((k - STABLE_CNT - 1 >= 0) && (hist[k-STABLE_CNT-1] === p)) ok = 1'b0;
      if (ok) apply_accept(p);
    end
  endtask

  task automatic check_all();
    check("bcd_out",    bcd_out,           m_bcd);
    check("dot_out",    32'(dot_out),      32'(m_dot));
    check("dig_valid",  32'(dig_valid),    32'(m_valid));
    check("err",        32'(err),          32'(m_err));
    check("err_dig",    32'(err_dig),      32'(m_err_dig));
    check("frame_done", 32'(frame_done),   32'(m_frame));
  endtask

  task automatic step(input logic [7:0] seg, input logic [7:0] com);
    seg_data = seg;
    seg_com  = com;
    @(posedge clk);
    #1;
    model_edge({seg, com});
    check_all();
    if (frame_done === 1'b1) frame_pulses++;
    if (err === 1'b1) err_pulses++;
  endtask

  task automatic hold(input logic [7:0] seg, input logic [7:0] com, input int n);
    for (int i = 0; i < n; i++) step(seg, com);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] snap_bcd;
    int          snap_err;
    int          d;
    int          kind;
    int          n;
    logic [7:0]  seg;
    logic [7:0]  com;

    rst_n    = 1'b1;
    seg_data = 8'b0110_0001;
    seg_com  = 8'b1111_1110;
    #2;
    do_reset(3);

    // First capture: valid exactly STABLE_CNT edges after the first sample.
    for (int i = 0; i < 5; i++) begin
      step(8'b0110_0001, 8'b1111_1110);
      check("first_valid", 32'(dig_valid), (i >= STABLE_CNT) ? 32'h1 : 32'h0);
    end
    check("first_bcd", 32'(bcd_out[3:0]), 32'h1);
    check("first_dot", 32'(dot_out[0]), 32'h1);

    // Glitch rejection on digit 2.
    hold(8'b1101_1010, com_of(2), 3);
    step(8'h00, 8'hFF);
    check("glitch_none", 32'(dig_valid[2]), 32'h0);
    hold(8'b1101_1010, com_of(2), 5);
    check("glitch_bcd", 32'(bcd_out[11:8]), 32'h2);
    check("glitch_dot", 32'(dot_out[2]), 32'h0);

    // Two full scans showing 7..0 on digits 0..7.
    frame_pulses = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_DIG; i++) hold(seg_of(7 - i, 1'b0), com_of(i), 6);
      check("frame_count", 32'(frame_pulses), 32'(pass + 1));
    end
    check("frame_bcd", bcd_out, 32'h0123_4567);

    // Blank digit and undecodable digit.
    hold(8'h00, com_of(5), 6);
    check("blank_bcd", 32'(bcd_out[23:20]), 32'hF);
    check("blank_valid", 32'(dig_valid[5]), 32'h1);
    err_pulses = 0;
    hold({7'b1000000, 1'b0}, com_of(3), 6);
    check("err_pulses", 32'(err_pulses), 32'h1);
    check("err_dig_3", 32'(err_dig), 32'h3);
    check("err_keep", 32'(bcd_out[15:12]), 32'h4);

    // Illegal selects never write or flag.
    snap_bcd = bcd_out;
    snap_err = err_pulses;
    hold(seg_of(8, 1'b1), 8'hFF, 10);
    hold(seg_of(8, 1'b1), 8'b1111_1100, 10);
    check("illegal_bcd", bcd_out, snap_bcd);
    check("illegal_err", 32'(err_pulses), 32'(snap_err));

    // Reset in the middle of a stability count.
    hold(seg_of(9, 1'b0), com_of(4), 2);
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      step(seg_of(9, 1'b0), com_of(4));
      check("rst_valid", 32'(dig_valid[4]), (i >= STABLE_CNT) ? 32'h1 : 32'h0);
    end

    // Random bus traffic.
    for (int r = 0; r < 200; r++) begin
      d    = int'($urandom_range(NUM_DIG - 1, 0));
      kind = int'($urandom_range(11, 0));
      n    = int'($urandom_range(7, 1));
      com  = com_of(d);
      if (kind <= 7)       seg = seg_of(int'($urandom_range(9, 0)), 1'($urandom));
      else if (kind == 8)  seg = {7'b0, 1'($urandom)};
      else if (kind == 9)  seg = 8'($urandom);
      else begin
        seg = seg_of(int'($urandom_range(9, 0)), 1'($urandom));
        com[(d + 1) % NUM_DIG] = 1'b0;
        if (kind == 11) com = 8'hFF;
      end
      hold(seg, com, n);
      if ($urandom_range(39, 0) == 0) do_reset(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
